// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared definitions for the register file slice.
//   - clr_state_t : clear sequencer states (IDLE, CLEAR), encodings kept as
//                   plain localparams so older code can still compare against them.
//   - clog2       : constant ceil(log2) used to size entry addresses.
package reg_file_pkg;

   localparam logic [0:0] IDLE_ENC  = 1'b0;
   localparam logic [0:0] CLEAR_ENC = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = IDLE_ENC,
      CLEAR = CLEAR_ENC
   } clr_state_t;

   function automatic int clog2(input int value);
      int result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq
//   Clear sequencer: on clr_req in IDLE it walks entries 0..DEPTH-1, one per
//   cycle, and then returns to IDLE. A clear lasts exactly DEPTH cycles and
//   clr_req seen while clearing is ignored.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_req     : single-cycle clear request
//   busy        : high while the sequence runs
//   clr_we      : zero the entry at clr_addr this cycle
//   clr_addr    : entry being cleared
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);

   clr_state_t    state_reg, state_next;
   logic [AW-1:0] cnt_reg, cnt_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (clr_req) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         CLEAR: begin
            if (cnt_reg == LAST_ENTRY) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign busy     = (state_reg == CLEAR);
   assign clr_we   = busy;
   assign clr_addr = cnt_reg;

endmodule

// File: rtl/reg_file.sv
// reg_file
//   General-purpose register bank: DEPTH words of WIDTH bits, one byte-masked
//   write port (valid/ready), two registered read ports, hardware clear.
//   Entry 0 is hard-wired to zero when ZERO_REG = 1. Writes to entries at or
//   above DEPTH, or to entry 0 with ZERO_REG = 1, are accepted and dropped.
//   Writes stall (wr_ready = 0) while a clear is running.
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   wr_valid/wr_ready               : write handshake
//   wr_addr, wr_data, wr_be         : write entry, data, byte enables
//   rd_en_a, rd_addr_a, rd_data_a   : read port A (1-cycle latency)
//   rd_en_b, rd_addr_b, rd_data_b   : read port B (1-cycle latency)
//   clr_req, busy                   : clear request, clear in progress
// Build option
//   REG_FILE_BYPASS_EN : a same-cycle read of the entry being written returns
//                        the merged post-write word instead of the old word.
module reg_file
   import reg_file_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int ZERO_REG = 1,
   localparam int AW       = clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [AW-1:0]      wr_addr,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic [WIDTH/8-1:0] wr_be,
   input  logic               rd_en_a,
   input  logic [AW-1:0]      rd_addr_a,
   output logic [WIDTH-1:0]   rd_data_a,
   input  logic               rd_en_b,
   input  logic [AW-1:0]      rd_addr_b,
   output logic [WIDTH-1:0]   rd_data_b,
   input  logic               clr_req,
   output logic               busy
);

   localparam int          NB      = WIDTH / 8;
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_reg  [DEPTH];
   logic [WIDTH-1:0] mem_next [DEPTH];

   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   logic             wr_keep;
   logic [WIDTH-1:0] wr_mask;
   logic [WIDTH-1:0] wr_old;
   logic [WIDTH-1:0] wr_word;

   // True for entries that physically store data.
   function automatic logic addr_ok(input logic [AW-1:0] addr);
      return ({1'b0, addr} < DEPTH_W) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   reg_file_clr_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign wr_ready = ~busy;
   // Accepted but discarded writes never reach the array or the bypass path.
   assign wr_keep  = wr_valid & wr_ready & addr_ok(wr_addr);

   for (genvar gi = 0; gi < NB; gi++) begin : g_mask
      assign wr_mask[8*gi +: 8] = {8{wr_be[gi]}};
   end

   assign wr_old  = addr_ok(wr_addr) ? mem_reg[wr_addr] : '0;
   assign wr_word = (wr_old & ~wr_mask) | (wr_data & wr_mask);

   // Clear and write never coincide (writes stall while busy); clear wins anyway.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign mem_next[gi] = (clr_we && (clr_addr == AW'(gi))) ? '0 :
                            (wr_keep && (wr_addr == AW'(gi))) ? wr_word :
                            mem_reg[gi];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      end else begin
         mem_reg <= mem_next;
      end
   end

   logic          rd_en_v;
   logic [1:0]    rd_en_pair;
   logic [AW-1:0] rd_addr_v [2];

   assign rd_en_pair   = {rd_en_b, rd_en_a};
   assign rd_en_v      = |rd_en_pair;
   assign rd_addr_v[0] = rd_addr_a;
   assign rd_addr_v[1] = rd_addr_b;

   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [WIDTH-1:0] rd_word;
      logic [WIDTH-1:0] data_reg;

      always_comb begin
         rd_word = '0;
         if (addr_ok(rd_addr_v[gi])) rd_word = mem_reg[rd_addr_v[gi]];
`ifdef REG_FILE_BYPASS_EN
         if (wr_keep && (wr_addr == rd_addr_v[gi])) rd_word = wr_word;
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_reg <= '0;
         end else if (rd_en_v && rd_en_pair[gi]) begin
            data_reg <= rd_word;
         end
      end
   end

   assign rd_data_a = g_rd[0].data_reg;
   assign rd_data_b = g_rd[1].data_reg;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   // default build: WIDTH 32, DEPTH 32, ZERO_REG 1
   logic        wr_valid, wr_ready;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_en_a, rd_en_b;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rd_data_a, rd_data_b;
   logic        clr_req, busy;
   // DEPTH 20 instance for out-of-range addressing
   logic        s_wr_valid, s_wr_ready;
   logic [4:0]  s_wr_addr;
   logic [31:0] s_wr_data;
   logic [3:0]  s_wr_be;
   logic        s_rd_en_a, s_rd_en_b;
   logic [4:0]  s_rd_addr_a, s_rd_addr_b;
   logic [31:0] s_rd_data_a, s_rd_data_b;
   logic        s_clr_req, s_busy;

   reg_file u_dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .clr_req(clr_req), .busy(busy)
   );

   reg_file #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1)) u_dut20 (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr),
      .wr_data(s_wr_data), .wr_be(s_wr_be),
      .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a), .rd_data_a(s_rd_data_a),
      .rd_en_b(s_rd_en_b), .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b),
      .clr_req(s_clr_req), .busy(s_busy)
   );

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] mdl   [32];
   logic [31:0] mdl20 [20];
   logic [31:0] exp_a_q [$];
   logic [31:0] exp_b_q [$];
   logic [31:0] last_a, last_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mdl_rd(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : mdl[a];
   endfunction

   task automatic mdl_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      if (a != 5'd0) mdl[a] = merge(mdl[a], d, be);
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
   endtask

   // All transaction tasks start and end just after a falling edge.
   task automatic do_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      check("wr_ready", {31'b0, wr_ready}, 32'h1);
      @(negedge clk);
      wr_valid = 1'b0;
      mdl_wr(a, d, be);
      $display("WR addr=%0d data=0x%08h be=%b", a, d, be);
   endtask

   task automatic do_rd(input logic ea, input logic [4:0] aa, input logic eb,
                        input logic [4:0] ab, input string tag);
      rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
      if (ea) last_a = mdl_rd(aa);
      if (eb) last_b = mdl_rd(ab);
      exp_a_q.push_back(last_a);
      exp_b_q.push_back(last_b);
      @(negedge clk);
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      check({tag, "_a"}, rd_data_a, exp_a_q.pop_front());
      check({tag, "_b"}, rd_data_b, exp_b_q.pop_front());
      $display("RD %s A(en=%0b,%0d)=0x%08h B(en=%0b,%0d)=0x%08h", tag, ea, aa, rd_data_a,
               eb, ab, rd_data_b);
   endtask

   // Write and read both ports in the same cycle.
   task automatic do_wr_rd(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                           input string tag);
      logic [31:0] want;
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      rd_en_a = 1'b1; rd_addr_a = a; rd_en_b = 1'b1; rd_addr_b = a;
      want = mdl_rd(a);
`ifdef REG_FILE_BYPASS_EN
      if (a != 5'd0) want = merge(mdl[a], d, be);
`endif
      last_a = want; last_b = want;
      exp_a_q.push_back(want);
      exp_b_q.push_back(want);
      @(negedge clk);
      wr_valid = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
      mdl_wr(a, d, be);
      check({tag, "_a"}, rd_data_a, exp_a_q.pop_front());
      check({tag, "_b"}, rd_data_b, exp_b_q.pop_front());
      $display("WRRD %s addr=%0d data=0x%08h be=%b A=0x%08h B=0x%08h", tag, a, d, be,
               rd_data_a, rd_data_b);
   endtask

   task automatic s_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      s_wr_valid = 1'b1; s_wr_addr = a; s_wr_data = d; s_wr_be = be;
      check("s_wr_ready", {31'b0, s_wr_ready}, 32'h1);
      @(negedge clk);
      s_wr_valid = 1'b0;
      if (a != 5'd0 && a < 5'd20) mdl20[a] = merge(mdl20[a], d, be);
      $display("WR20 addr=%0d data=0x%08h be=%b", a, d, be);
   endtask

   task automatic s_rd(input logic [4:0] a);
      s_rd_en_a = 1'b1; s_rd_addr_a = a;
      exp_a_q.push_back((a == 5'd0 || a >= 5'd20) ? 32'h0 : mdl20[a]);
      @(negedge clk);
      s_rd_en_a = 1'b0;
      check("t3_rd20", s_rd_data_a, exp_a_q.pop_front());
      $display("RD20 addr=%0d data=0x%08h", a, s_rd_data_a);
   endtask

   initial begin
      int cnt;
      int bad;
      rst_n = 1'b0;
      wr_valid = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
      rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0; clr_req = 0;
      s_wr_valid = 0; s_wr_addr = 0; s_wr_data = 0; s_wr_be = 0;
      s_rd_en_a = 0; s_rd_addr_a = 0; s_rd_en_b = 0; s_rd_addr_b = 0; s_clr_req = 0;
      mdl_clear();
      for (int i = 0; i < 20; i++) mdl20[i] = 32'h0;
      last_a = 0; last_b = 0;

      // 1: reset state
      repeat (2) @(negedge clk);
      check("rst_rd_a", rd_data_a, 32'h0);
      check("rst_rd_b", rd_data_b, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_wr_ready", {31'b0, wr_ready}, 32'h1);
      rst_n = 1'b1;
      @(negedge clk);
      do_rd(1'b1, 5'd3, 1'b1, 5'd31, "t1");

      // 2: byte-masked writes, zero-mask no-op, hold when disabled
      do_wr(5'd5, 32'hDEADBEEF, 4'b1111);
      do_wr(5'd5, 32'h00001200, 4'b0010);
      do_wr(5'd5, 32'hFFFFFFFF, 4'b0000);
      do_rd(1'b1, 5'd5, 1'b1, 5'd5, "t2");
      do_wr(5'd9, 32'hA1B2C3D4, 4'b1001);
      do_rd(1'b0, 5'd9, 1'b1, 5'd9, "t2_hold");

      // 3 (DEPTH 32 part): entry 0 hard zero
      do_wr(5'd0, 32'hFFFFFFFF, 4'b1111);
      do_rd(1'b1, 5'd0, 1'b1, 5'd5, "t3_zero");

      // 5: read-during-write, including a discarded write to entry 0
      do_wr(5'd7, 32'h77777777, 4'b1111);
      do_wr_rd(5'd7, 32'h00000011, 4'b0001, "t5_rdw");
      do_rd(1'b1, 5'd7, 1'b1, 5'd7, "t5_after");
      do_wr_rd(5'd0, 32'h12345678, 4'b1111, "t5_rdw0");

      // 4: fill, then clear with a concurrent write and a pending write
      for (int i = 0; i < 32; i++) do_wr(5'(i), 32'(i), 4'b1111);
      clr_req = 1'b1;
      wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 32'h55555555; wr_be = 4'b1111;
      check("t4_wr_with_clr", {31'b0, wr_ready}, 32'h1);
      @(negedge clk);
      clr_req = 1'b0;
      mdl_wr(5'd4, 32'h55555555, 4'b1111);
      wr_addr = 5'd3; wr_data = 32'h000000A5;
      cnt = 0; bad = 0;
      while (busy && cnt < 100) begin
         cnt++;
         if (wr_ready) bad++;
         clr_req = (cnt == 10);
         @(negedge clk);
      end
      clr_req = 1'b0;
      $display("CLR busy_cycles=%0d wr_ready_high=%0d", cnt, bad);
      check("t4_busy_cycles", 32'(cnt), 32'd32);
      check("t4_wr_ready_low", 32'(bad), 32'd0);
      @(negedge clk);
      wr_valid = 1'b0;
      mdl_clear();
      mdl_wr(5'd3, 32'h000000A5, 4'b1111);
      for (int i = 0; i < 32; i++) do_rd(1'b1, 5'(i), 1'b1, 5'(31 - i), "t4_rd");

      // 6: reset in the middle of a clear
      for (int i = 0; i < 32; i++) do_wr(5'(i), 32'h100 + 32'(i), 4'b1111);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 5; i++) mdl[i] = 32'h0;
      do_rd(1'b1, 5'd20, 1'b1, 5'd2, "t6_partial");
      repeat (4) @(negedge clk);
      check("t6_busy_mid", {31'b0, busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_busy_rst", {31'b0, busy}, 32'h0);
      check("t6_wr_ready_rst", {31'b0, wr_ready}, 32'h1);
      check("t6_rd_a_rst", rd_data_a, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      mdl_clear();
      last_a = 0; last_b = 0;
      for (int i = 0; i < 32; i++) mdl20[i % 20] = 32'h0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) do_rd(1'b1, 5'(i), 1'b1, 5'(31 - i), "t6_rd");
      do_wr(5'd12, 32'hCAFEF00D, 4'b1111);
      do_rd(1'b1, 5'd12, 1'b0, 5'd0, "t6_wr");

      // 3 (DEPTH 20 part): out-of-range writes dropped, reads 0
      s_wr(5'd19, 32'h13131313, 4'b1111);
      s_wr(5'd0, 32'hFFFFFFFF, 4'b1111);
      s_wr(5'd25, 32'hFFFFFFFF, 4'b1111);
      s_wr(5'd31, 32'hEEEEEEEE, 4'b1111);
      s_wr(5'd6, 32'h0000AB00, 4'b0010);
      for (int i = 0; i < 20; i++) s_rd(5'(i));
      s_rd(5'd25);
      s_rd(5'd31);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
